bridge_rx_param: RTL and testbench

- Parametrised successor to the host-to-bus receive bridge. Parses ASCII-hex request frames arriving byte-wise from the UART receiver.
- Issues one bus transaction per frame (read or write) to the downstream core chain.
- Holds each transaction with a true valid/ready handshake, so the downstream chain may stall.
- Address/data widths are generic; the block adds lowercase hex, error reporting and resynchronisation.

---
 rtl/bridge_rx_param_if.sv | 30 +++
 rtl/bridge_rx_param.sv | 198 +++++++++++++++++++
 tb/tb_bridge_rx_param.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/bridge_rx_param_if.sv
`default_nettype none
// ============================================================================
// Module   : bridge_rx_param_if
// Brief    : Byte-input / bus-output bundle of the host-to-bus receive bridge.
// Revision : 1.0
// ============================================================================
interface bridge_rx_param_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 16
);
  logic [7:0]            rx_data;
  logic                  rx_valid;
  logic [ADDR_WIDTH-1:0] addr_o;
  logic [DATA_WIDTH-1:0] wdata_o;
  logic                  rw_o;
  logic                  valid_o;
  logic                  ready_i;
  logic                  err_o;

  // master is the bridge side; slave is the UART/downstream side
  modport master (
    input  rx_data, rx_valid, ready_i,
    output addr_o, wdata_o, rw_o, valid_o, err_o
  );
  modport slave (
    output rx_data, rx_valid, ready_i,
    input  addr_o, wdata_o, rw_o, valid_o, err_o
  );
endinterface
`default_nettype wire

// File: rtl/bridge_rx_param.sv
`default_nettype none
// ============================================================================
// Module   : bridge_rx_param
// Brief    : ASCII-hex frame parser issuing one valid/ready bus transaction per
//            frame. Optional idle timeout: BRIDGE_RX_PARAM_TIMEOUT_EN.
// Revision : 1.0
// ============================================================================
module bridge_rx_param #(
  parameter int         ADDR_WIDTH     = 16,
  parameter int         DATA_WIDTH     = 16,
  parameter logic [7:0] PREAMBLE       = 8'h4D,
  parameter int         TIMEOUT_CYCLES = 1000000
) (
  input  wire logic         clk,
  input  wire logic         rst,
  bridge_rx_param_if.master bus
);
  localparam int AD   = ADDR_WIDTH / 4;
  localparam int DD   = DATA_WIDTH / 4;
  localparam int MAXD = (AD > DD) ? AD : DD;
  localparam int CW   = $clog2(MAXD + 1);
  localparam logic [CW-1:0] AD_C = CW'(AD);
  localparam logic [CW-1:0] DD_C = CW'(DD);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ADDR  = 3'd1,
    S_DATA  = 3'd2,
    S_ISSUE = 3'd3,
    S_ERROR = 3'd4
  } state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_sr_q, addr_sr_d, addr_q, addr_d;
  logic [DATA_WIDTH-1:0] data_sr_q, data_sr_d, wdata_q, wdata_d;
  logic                  rw_q, rw_d, valid_q, valid_d, pend_q, pend_d, err_q, err_d;
  logic                  w_is_hex, w_is_term;
  logic [3:0]            w_hex_val;

  always_comb begin
    w_is_hex  = 1'b1;
    w_hex_val = bus.rx_data[3:0];
    if (bus.rx_data >= 8'h30 && bus.rx_data <= 8'h39) begin
      w_hex_val = bus.rx_data[3:0];
    end else if ((bus.rx_data >= 8'h41 && bus.rx_data <= 8'h46) ||
                 (bus.rx_data >= 8'h61 && bus.rx_data <= 8'h66)) begin
      w_hex_val = bus.rx_data[3:0] + 4'd9;
    end else begin
      w_is_hex = 1'b0;
    end
  end

  assign w_is_term = (bus.rx_data == 8'h0D) || (bus.rx_data == 8'h0A);

`ifdef BRIDGE_RX_PARAM_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_q, tmo_d;
`else
  logic w_unused_tmo;
  assign w_unused_tmo = |TIMEOUT_CYCLES;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_sr_d = addr_sr_q;
    data_sr_d = data_sr_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rw_d      = rw_q;
    valid_d   = valid_q;
    pend_d    = pend_q;
    err_d     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (bus.rx_valid && bus.rx_data == PREAMBLE) begin
          state_d   = S_ADDR;
          cnt_d     = '0;
          addr_sr_d = '0;
          data_sr_d = '0;
        end
      end
      S_ADDR: begin
        if (bus.rx_valid) begin
          if (w_is_hex && cnt_q == AD_C) begin
            // an extra digit after a full address is the first data digit
            state_d   = S_DATA;
            data_sr_d = DATA_WIDTH'(w_hex_val);
            cnt_d     = CW'(1);
          end else if (w_is_hex) begin
            addr_sr_d = (addr_sr_q << 4) | ADDR_WIDTH'(w_hex_val);
            cnt_d     = cnt_q + 1'b1;
          end else if (w_is_term && cnt_q == AD_C) begin
            state_d = S_ISSUE;
            addr_d  = addr_sr_q;
            wdata_d = '0;
            rw_d    = 1'b0;
            valid_d = 1'b1;
          end else begin
            state_d = S_ERROR;
            err_d   = 1'b1;
          end
        end
      end
      S_DATA: begin
        if (bus.rx_valid) begin
          if (w_is_hex && cnt_q != DD_C) begin
            data_sr_d = (data_sr_q << 4) | DATA_WIDTH'(w_hex_val);
            cnt_d     = cnt_q + 1'b1;
          end else if (w_is_term && cnt_q == DD_C) begin
            state_d = S_ISSUE;
            addr_d  = addr_sr_q;
            wdata_d = data_sr_q;
            rw_d    = 1'b1;
            valid_d = 1'b1;
          end else begin
            state_d = S_ERROR;
            err_d   = 1'b1;
          end
        end
      end
      S_ISSUE: begin
        // the UART cannot be stalled: flag the overrun once, keep the transaction
        if (bus.rx_valid && !w_is_term && !pend_q) begin
          pend_d = 1'b1;
          err_d  = 1'b1;
        end
        if (valid_q && bus.ready_i) begin
          valid_d = 1'b0;
          state_d = pend_d ? S_ERROR : S_IDLE;
          pend_d  = 1'b0;
        end
      end
      S_ERROR: begin
        if (bus.rx_valid && w_is_term) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
`ifdef BRIDGE_RX_PARAM_TIMEOUT_EN
    tmo_d = '0;
    if ((state_q == S_ADDR || state_q == S_DATA) && !bus.rx_valid) begin
      if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
        state_d = S_IDLE;
        err_d   = 1'b1;
      end else begin
        tmo_d = tmo_q + 1'b1;
      end
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      addr_sr_q <= '0;
      data_sr_q <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rw_q      <= 1'b0;
      valid_q   <= 1'b0;
      pend_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_sr_q <= addr_sr_d;
      data_sr_q <= data_sr_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rw_q      <= rw_d;
      valid_q   <= valid_d;
      pend_q    <= pend_d;
      err_q     <= err_d;
    end
  end

`ifdef BRIDGE_RX_PARAM_TIMEOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_q <= '0;
    end else begin
      tmo_q <= tmo_d;
    end
  end
`endif

  assign bus.addr_o  = addr_q;
  assign bus.wdata_o = wdata_q;
  assign bus.rw_o    = rw_q;
  assign bus.valid_o = valid_q;
  assign bus.err_o   = err_q;

endmodule
`default_nettype wire

// File: tb/tb_bridge_rx_param.sv
`default_nettype none
// Scoreboard bench for bridge_rx_param: a 16/16 instance and an 8/32 instance.
module tb_bridge_rx_param;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bridge_rx_param_if #(.ADDR_WIDTH(16), .DATA_WIDTH(16)) ifa ();
  bridge_rx_param_if #(.ADDR_WIDTH(8),  .DATA_WIDTH(32)) ifw ();

  bridge_rx_param #(.ADDR_WIDTH(16), .DATA_WIDTH(16), .PREAMBLE(8'h4D), .TIMEOUT_CYCLES(50))
    u_dut (.clk(clk), .rst(rst), .bus(ifa));
  bridge_rx_param #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .PREAMBLE(8'h4D), .TIMEOUT_CYCLES(50))
    u_wide (.clk(clk), .rst(rst), .bus(ifw));

  typedef struct packed { logic [15:0] a; logic [15:0] d; logic rw; } txn_a_t;
  typedef struct packed { logic [7:0]  a; logic [31:0] d; logic rw; } txn_w_t;
  txn_a_t qa[$];
  txn_w_t qw[$];

  int total = 0;
  int bad   = 0;
  int err_a = 0, err_w = 0, vcyc_a = 0, vcyc_w = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // monitors sample on the falling edge, away from the active edge
  always @(negedge clk) begin
    if (!rst) begin
      if (ifa.err_o) err_a++;
      if (ifw.err_o) err_w++;
      if (ifa.valid_o) begin
        vcyc_a++;
        if (qa.size() == 0) check("a_unexpected_txn", 64'(qa.size()), 64'd1);
        else begin
          check("a_addr", 64'(ifa.addr_o), 64'(qa[0].a));
          check("a_wdata", 64'(ifa.wdata_o), 64'(qa[0].d));
          check("a_rw", 64'(ifa.rw_o), 64'(qa[0].rw));
          if (ifa.ready_i) void'(qa.pop_front());
        end
      end
      if (ifw.valid_o) begin
        vcyc_w++;
        if (qw.size() == 0) check("w_unexpected_txn", 64'(qw.size()), 64'd1);
        else begin
          check("w_addr", 64'(ifw.addr_o), 64'(qw[0].a));
          check("w_wdata", 64'(ifw.wdata_o), 64'(qw[0].d));
          check("w_rw", 64'(ifw.rw_o), 64'(qw[0].rw));
          if (ifw.ready_i) void'(qw.pop_front());
        end
      end
    end
  end

  task automatic send_byte(input int sel, input logic [7:0] b);
    @(posedge clk); #1;
    if (sel == 0) begin ifa.rx_data = b; ifa.rx_valid = 1'b1; end
    else          begin ifw.rx_data = b; ifw.rx_valid = 1'b1; end
    @(posedge clk); #1;
    ifa.rx_valid = 1'b0;
    ifw.rx_valid = 1'b0;
  endtask

  task automatic send_str(input int sel, input string s);
    for (int i = 0; i < s.len(); i++) send_byte(sel, s[i]);
  endtask

  task automatic drain();
    for (int i = 0; i < 300 && (qa.size() != 0 || qw.size() != 0); i++) @(negedge clk);
    check("drain", 64'(qa.size() + qw.size()), 64'd0);
    repeat (3) @(posedge clk);
  endtask

  int e0, v0;

  initial begin
    ifa.rx_data = 8'h00; ifa.rx_valid = 1'b0; ifa.ready_i = 1'b0;
    ifw.rx_data = 8'h00; ifw.rx_valid = 1'b0; ifw.ready_i = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_outs_a", {ifa.addr_o, ifa.wdata_o, ifa.rw_o, ifa.valid_o, ifa.err_o}, 64'd0);
    check("rst_outs_w", {ifw.addr_o, ifw.wdata_o, ifw.rw_o, ifw.valid_o, ifw.err_o}, 64'd0);
    @(posedge clk); #1 rst = 1'b0;

    // read with ready tied high
    ifa.ready_i = 1'b1; ifw.ready_i = 1'b1;
    e0 = err_a; v0 = vcyc_a;
    qa.push_back('{a: 16'h0012, d: 16'h0000, rw: 1'b0});
    send_str(0, "M0012"); send_byte(0, 8'h0D);
    drain();
    check("read_valid_cycles", 64'(vcyc_a - v0), 64'd1);
    check("read_no_err", 64'(err_a - e0), 64'd0);

    // write with 5-cycle stall
    ifa.ready_i = 1'b0;
    v0 = vcyc_a;
    qa.push_back('{a: 16'h00A3, d: 16'hBEEF, rw: 1'b1});
    send_str(0, "M00A3BEEF"); send_byte(0, 8'h0A);
    for (int i = 0; i < 20 && !ifa.valid_o; i++) @(negedge clk);
    if (!ifa.valid_o) @(negedge clk);
    check("stall_valid_rise", 64'(ifa.valid_o), 64'd1);
    repeat (5) @(posedge clk);
    #1 ifa.ready_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("stall_valid_drop", 64'(ifa.valid_o), 64'd0);
    check("stall_valid_cycles", 64'(vcyc_a - v0), 64'd6);
    drain();

    // error and resync
    e0 = err_a;
    send_str(0, "M00G1"); send_byte(0, 8'h0D);
    repeat (2) @(posedge clk);
    check("bad_digit_err", 64'(err_a - e0), 64'd1);
    qa.push_back('{a: 16'h0001, d: 16'h0000, rw: 1'b0});
    send_byte(0, 8'h0A); send_str(0, "M0001"); send_byte(0, 8'h0D);
    drain();
    check("resync_err_total", 64'(err_a - e0), 64'd1);

    // lowercase hex and wide data
    e0 = err_w; v0 = vcyc_w;
    qw.push_back('{a: 8'h7F, d: 32'hDEADBEEF, rw: 1'b1});
    send_str(1, "M7fdeadbeef"); send_byte(1, 8'h0D);
    drain();
    check("wide_no_err", 64'(err_w - e0), 64'd0);
    v0 = vcyc_w;
    send_str(1, "M7"); send_byte(1, 8'h0D);
    repeat (3) @(posedge clk);
    check("short_addr_err", 64'(err_w - e0), 64'd1);
    check("short_addr_no_txn", 64'(vcyc_w - v0), 64'd0);

    // overrun while the transaction is held
    ifa.ready_i = 1'b0;
    e0 = err_a;
    qa.push_back('{a: 16'h0004, d: 16'h0000, rw: 1'b0});
    send_str(0, "M0004"); send_byte(0, 8'h0D);
    send_str(0, "Mx"); send_byte(0, 8'h0D);
    repeat (2) @(posedge clk);
    check("overrun_err_once", 64'(err_a - e0), 64'd1);
    check("overrun_still_held", 64'(ifa.valid_o), 64'd1);
    #1 ifa.ready_i = 1'b1;
    drain();
    v0 = vcyc_a;
    send_str(0, "M0005"); send_byte(0, 8'h0D);
    repeat (3) @(posedge clk);
    check("overrun_frame_dropped", 64'(vcyc_a - v0), 64'd0);
    qa.push_back('{a: 16'h0006, d: 16'h0000, rw: 1'b0});
    send_str(0, "M0006"); send_byte(0, 8'h0D);
    drain();
    check("overrun_err_total", 64'(err_a - e0), 64'd1);

    // reset mid-frame
    e0 = err_a; v0 = vcyc_a;
    send_str(0, "M00");
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    check("midrst_outs", {ifa.addr_o, ifa.wdata_o, ifa.rw_o, ifa.valid_o, ifa.err_o}, 64'd0);
    @(posedge clk); #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    check("midrst_no_err", 64'(err_a - e0), 64'd0);
    check("midrst_no_txn", 64'(vcyc_a - v0), 64'd0);
    qa.push_back('{a: 16'h0003, d: 16'h0000, rw: 1'b0});
    send_str(0, "M0003"); send_byte(0, 8'h0D);
    drain();

`ifdef BRIDGE_RX_PARAM_TIMEOUT_EN
    e0 = err_a;
    send_str(0, "M0");
    repeat (44) @(posedge clk);
    check("tmo_not_early", 64'(err_a - e0), 64'd0);
    repeat (10) @(posedge clk);
    check("tmo_err", 64'(err_a - e0), 64'd1);
    qa.push_back('{a: 16'h0003, d: 16'h0000, rw: 1'b0});
    send_str(0, "M0003"); send_byte(0, 8'h0D);
    drain();
    check("tmo_resync_err", 64'(err_a - e0), 64'd1);
`endif

    check("sb_empty", 64'(qa.size() + qw.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
